mix_columns_seq: RTL and testbench
==================================

// Module: mix_columns_seq
// PURPOSE
//  Sequential, parametrised AES MixColumns / InvMixColumns engine with a runtime direction select.
//  Processes COLS_PER_CYC state columns per clock, so area can be traded against latency.
//  Sits between the ShiftRows and AddRoundKey stages of the iterative AES round datapath.
//  Uses valid/ready handshakes on both sides; one 128-bit state is in flight at a time.
// PARAMETERS
//  COLS_PER_CYC  1  columns transformed per cycle; legal values 1, 2, 4; any other value is an elaboration error
//  OUT_ZERO_IDLE 1  1: out_data is forced to 0 whenever out_valid=0; 0: out_data holds the last result
// PORTS
//  clk        in   1    clock; all logic on the rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    in_data/in_inv are valid
//  in_ready   out  1    engine can accept a state
//  in_data    in   128  AES state, row-major: byte(row r, col c) = bits [127-32r-8c -: 8]
//  in_inv     in   1    0 = MixColumns, 1 = InvMixColumns; sampled at acceptance only
//  out_valid  out  1    out_data is valid
//  out_ready  in   1    downstream accepts out_data
//  out_data   out  128  transformed state, same byte layout as in_data
// BEHAVIOUR
//  - Reset: FSM goes to IDLE; col counter, state register and mode register are cleared; out_valid=0; out_data=0.
//    in_ready=0 in any cycle with rst=1.
//  - FSM states: IDLE, BUSY, DONE.
//  - IDLE: in_ready=1.
//    in_valid&in_ready -> latch in_data and in_inv, col_idx<=0, go to BUSY.
//  - BUSY: in_ready=0, out_valid=0.
//    Each cycle, transform columns col_idx .. col_idx+COLS_PER_CYC-1 in place, then col_idx += COLS_PER_CYC.
//    Go to DONE on the cycle col_idx+COLS_PER_CYC == 4. col_idx is 2 bits and wraps to 0.
//  - DONE: out_valid=1, in_ready=0; out_data is stable until the handshake completes.
//    out_ready=1 -> go to IDLE.
//  - Latency: acceptance at edge T -> out_valid high after edge T+4/COLS_PER_CYC (4, 2 or 1 cycles).
//    Minimum acceptance spacing is 4/COLS_PER_CYC+2 cycles when out_ready is held high.
//  - No combinational path from in_* to out_*, nor from out_ready to in_ready.
//    in_ready and out_valid are decodes of the FSM state only.
//  - Column transform over GF(2^8), polynomial 0x11b; xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0), 8-bit result.
//    Forward matrix: rows {2,3,1,1}, cyclically rotated.
//    Inverse matrix: rows {e,b,d,9}, cyclically rotated.
//  - Backpressure: DONE persists indefinitely while out_ready=0. in_valid is ignored outside IDLE
//    (in_ready=0, so no data is lost).
//  - in_inv changing after acceptance has no effect on the state in flight.
//  - Reset mid-operation (BUSY or DONE): the state in flight is discarded without any output.
//    The next state is accepted starting in the cycle after rst deasserts.
//  - OUT_ZERO_IDLE=1: out_data=0 outside DONE. Otherwise out_data is the raw state register.
// STRUCTURE
//  - aes_pkg holds:
//    - constants AES_BLOCK_W=128 and AES_POLY=8'h1b
//    - typedef mc_state_e {IDLE,BUSY,DONE}
//    - functions xtime, gmul_by_{2,3,9,b,d,e}
//  - Sub-module mix_column_word: combinational; ports col_in[31:0] (row0 in MSB), inv, col_out[31:0].
//    Instantiated COLS_PER_CYC times. The column select muxes are driven by col_idx.
//  - The top level holds the FSM, col_idx, the 128-bit state register, the mode register and the output gating.
// TESTING (run every case for COLS_PER_CYC = 1, 2 and 4)
//  1. Forward, column vectors
//     Input columns: c0=db135345, c1=f20a225c, c2=01010101, c3=d4d4d4d5.
//     Expected out columns: 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6.
//     out_valid must rise exactly 4/COLS_PER_CYC cycles after acceptance.
//  2. Inverse of case 1 output with in_inv=1 -> original columns db135345, f20a225c, 01010101, d4d4d4d5.
//  3. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//     Required: out_data stable, in_ready=0, and a new in_valid is not accepted.
//     Release out_ready -> IDLE on the next cycle, then the next state is accepted.
//  4. Toggle in_inv every cycle while the engine is BUSY -> result still matches the mode latched at acceptance.
//  5. Assert rst during BUSY (after 1 cycle) -> no out_valid pulse is produced and out_data=0.
//     A following forward state of all columns c6c6c6c6 must yield c6c6c6c6.
//  6. Random back-to-back stream of 1000 states with random mode, in_valid and out_ready.
//     Scoreboard against a reference model; every accepted state produces exactly one output, in order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns engine: block width, reduction polynomial,
// FSM state type, GF(2^8) constant multipliers and column pack/unpack helpers.
package aes_pkg;

    localparam int         AES_BLOCK_W = 128;
    localparam logic [7:0] AES_POLY    = 8'h1b;

    // Row-0 coefficients of the circulant matrices, one nibble per term
    localparam logic [15:0] FWD_COEFS = 16'h2311;
    localparam logic [15:0] INV_COEFS = 16'hebd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_by_2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul_by_3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul_by_9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul_by_b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul_by_d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul_by_e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [7:0] gmul_const(input logic [3:0] k, input logic [7:0] b);
        logic [7:0] p;
        case (k)
            4'h1:    p = b;
            4'h2:    p = gmul_by_2(b);
            4'h3:    p = gmul_by_3(b);
            4'h9:    p = gmul_by_9(b);
            4'hb:    p = gmul_by_b(b);
            4'hd:    p = gmul_by_d(b);
            4'he:    p = gmul_by_e(b);
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    // The state is row-major, so a column is four bytes spaced one row (32 bits) apart
    function automatic logic [31:0] get_col(input logic [AES_BLOCK_W-1:0] s, input logic [1:0] c);
        logic [31:0] col;
        for (int r = 0; r < 4; r++)
            col[31-8*r -: 8] = s[127-32*r-8*int'(c) -: 8];
        return col;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] put_col(input logic [AES_BLOCK_W-1:0] s,
                                                        input logic [1:0] c,
                                                        input logic [31:0] col);
        logic [AES_BLOCK_W-1:0] res;
        res = s;
        for (int r = 0; r < 4; r++)
            res[127-32*r-8*int'(c) -: 8] = col[31-8*r -: 8];
        return res;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (row 0 in the MSB byte).
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [15:0] coefs;
    logic [7:0]  acc;

    // Output row r uses the row-0 coefficients rotated right by r
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        coefs   = inv ? INV_COEFS : FWD_COEFS;
        col_out = '0;
        acc     = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++)
                acc ^= gmul_const(coefs[15-4*k -: 4], col_in[31-8*((r+k)%4) -: 8]);
            col_out[31-8*r -: 8] = acc;
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns engine: one state in flight, COLS_PER_CYC columns rewritten in place per clock.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYC  = 1,
    parameter bit OUT_ZERO_IDLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data
);

    if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYC must be 1, 2 or 4");
    end

    mc_state_e              fsm_q;
    logic [1:0]             col_idx_q;
    logic [AES_BLOCK_W-1:0] data_q;
    logic [AES_BLOCK_W-1:0] data_next;
    logic                   inv_q;
    logic                   last_step;
    logic [31:0]            col_in  [COLS_PER_CYC];
    logic [31:0]            col_out [COLS_PER_CYC];

    for (genvar j = 0; j < COLS_PER_CYC; j++) begin : g_col
        assign col_in[j] = get_col(data_q, col_idx_q + 2'(j));

        mix_column_word u_word (
            .col_in  (col_in[j]),
            .inv     (inv_q),
            .col_out (col_out[j])
        );
    end

    always_comb begin
        data_next = data_q;
        for (int j = 0; j < COLS_PER_CYC; j++)
            data_next = put_col(data_next, col_idx_q + 2'(j), col_out[j]);
    end

    assign last_step = (int'(col_idx_q) + COLS_PER_CYC) == 4;

    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            fsm_q     <= IDLE;
            col_idx_q <= '0;
            data_q    <= '0;
            inv_q     <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: if (in_valid) begin
                    data_q    <= in_data;
                    inv_q     <= in_inv;
                    col_idx_q <= '0;
                    fsm_q     <= BUSY;
                end
                BUSY: begin
                    data_q    <= data_next;
                    col_idx_q <= col_idx_q + 2'(COLS_PER_CYC);
                    if (last_step)
                        fsm_q <= DONE;
                end
                DONE: if (out_ready)
                    fsm_q <= IDLE;
                default: fsm_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state only; rst just masks acceptance
    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign out_valid = (fsm_q == DONE);
    assign out_data  = (OUT_ZERO_IDLE && !out_valid) ? '0 : data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench: directed and random traffic against all three COLS_PER_CYC builds in parallel.
module tb_mix_columns_seq;

    logic clk;
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: generic GF(2^8) multiply and an explicit circulant matrix product
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   row0 [4];
        logic [7:0]   acc;
        logic [127:0] res = '0;
        if (inv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gf_mul(row0[(k - r + 4) % 4], s[127-32*k-8*c -: 8]);
                res[127-32*r-8*c -: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [127:0] cols2state(input logic [31:0] c0, input logic [31:0] c1,
                                                input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0]  cols [4];
        logic [127:0] s;
        cols = '{c0, c1, c2, c3};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[127-32*r-8*c -: 8] = cols[c][31-8*r -: 8];
        return s;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int C   = 1 << g;
        localparam int LAT = 4 / C;
        localparam int N_STREAM = 1000;

        logic         rst, in_valid, in_ready, in_inv, out_valid, out_ready;
        logic [127:0] in_data, out_data;
        logic         fin = 1'b0;

        mix_columns_seq #(.COLS_PER_CYC(C), .OUT_ZERO_IDLE(1'b1)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_inv    (in_inv),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
        );

        function automatic string tag(input string s);
            return $sformatf("cpc%0d_%s", C, s);
        endfunction

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic accept(input logic [127:0] d, input logic inv);
            int w = 0;
            in_valid = 1'b1;
            in_data  = d;
            in_inv   = inv;
            while (!in_ready && w < 50) begin step(); w++; end
            check(tag("accept_ready"), 128'(in_ready), 128'(1));
            step();
            in_valid = 1'b0;
            check(tag("busy_valid"), 128'(out_valid), 128'(0));
            check(tag("busy_data_zero"), out_data, 128'(0));
        endtask

        task automatic wait_out(input logic toggle);
            int lat = 0;
            while (!out_valid && lat < 20) begin
                if (toggle) in_inv = ~in_inv;
                step();
                lat++;
            end
            check(tag("latency"), 128'(lat), 128'(LAT));
        endtask

        task automatic finish_out();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        endtask

        task automatic run_case(input string name, input logic [127:0] d, input logic inv,
                                input logic [127:0] exp, input logic toggle);
            accept(d, inv);
            wait_out(toggle);
            check(tag(name), out_data, exp);
            finish_out();
        endtask

        task automatic run_stream();
            logic [127:0] q [$];
            logic [127:0] d;
            logic         iv;
            int           sent = 0;
            int           got  = 0;
            int           cyc  = 0;
            d  = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom_range(0, 1));
            while (got < N_STREAM && cyc < 40000) begin
                in_valid  = (sent < N_STREAM) && ($urandom_range(0, 3) != 0);
                in_data   = d;
                in_inv    = iv;
                out_ready = ($urandom_range(0, 2) != 0);
                if (in_valid && in_ready) begin
                    q.push_back(ref_mix(d, iv));
                    sent++;
                    d  = {$urandom, $urandom, $urandom, $urandom};
                    iv = 1'($urandom_range(0, 1));
                end
                if (out_valid && out_ready) begin
                    check(tag("stream_pending"), 128'(q.size() > 0), 128'(1));
                    if (q.size() > 0) check(tag("stream_data"), out_data, q.pop_front());
                    got++;
                end
                step();
                cyc++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check(tag("stream_outputs"), 128'(got), 128'(N_STREAM));
            check(tag("stream_leftover"), 128'(q.size()), 128'(0));
        endtask

        initial begin
            logic [127:0] v1, v1_fwd, v_other, v_rand, c6;
            v1      = cols2state(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5);
            v1_fwd  = cols2state(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6);
            c6      = {4{32'hc6c6c6c6}};

            rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
            step();
            step();
            check(tag("rst_in_ready"), 128'(in_ready), 128'(0));
            check(tag("rst_out_valid"), 128'(out_valid), 128'(0));
            check(tag("rst_out_data"), out_data, 128'(0));
            rst = 1'b0;
            step();
            check(tag("idle_in_ready"), 128'(in_ready), 128'(1));

            run_case("fwd_vectors", v1, 1'b0, v1_fwd, 1'b0);
            run_case("inv_vectors", v1_fwd, 1'b1, v1, 1'b0);

            // Backpressure: result held in DONE while a competing input waits
            v_other = {$urandom, $urandom, $urandom, $urandom};
            accept(v1, 1'b0);
            wait_out(1'b0);
            in_valid = 1'b1;
            in_data  = v_other;
            in_inv   = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                check(tag("bp_data_stable"), out_data, v1_fwd);
                check(tag("bp_in_ready"), 128'(in_ready), 128'(0));
                check(tag("bp_out_valid"), 128'(out_valid), 128'(1));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check(tag("bp_release_ready"), 128'(in_ready), 128'(1));
            check(tag("bp_release_valid"), 128'(out_valid), 128'(0));
            step();
            in_valid = 1'b0;
            wait_out(1'b0);
            check(tag("bp_next_state"), out_data, ref_mix(v_other, 1'b0));
            finish_out();

            // Mode toggling while busy must not leak into the state in flight
            v_rand = {$urandom, $urandom, $urandom, $urandom};
            run_case("toggle_inv1", v_rand, 1'b1, ref_mix(v_rand, 1'b1), 1'b1);
            v_rand = {$urandom, $urandom, $urandom, $urandom};
            run_case("toggle_inv0", v_rand, 1'b0, ref_mix(v_rand, 1'b0), 1'b1);

            // Reset one cycle into BUSY discards the state
            accept(v1, 1'b0);
            rst = 1'b1;
            step();
            check(tag("midrst_in_ready"), 128'(in_ready), 128'(0));
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step();
                check(tag("midrst_no_valid"), 128'(out_valid), 128'(0));
                check(tag("midrst_data_zero"), out_data, 128'(0));
            end
            run_case("c6_after_rst", c6, 1'b0, c6, 1'b0);

            run_stream();
            fin = 1'b1;
        end
    end

    initial begin
        logic all_done;
        all_done = 1'b0;
        for (int t = 0; t < 90000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g_cfg[0].fin & g_cfg[1].fin & g_cfg[2].fin;
        end
        check("all_configs_done", 128'(all_done), 128'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
